// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared types and helpers for the bit-serial add/subtract sequencer.
// Holds the FSM state encoding and the counter-width helper.
package serial_addsub_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bits needed to count 0..value-1. Never returns less than one bit.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/serial_addsub_ctrl_add1b.sv
// Existing 1-bit adder-subtractor slice: optionally inverts b and produces the sum bit.
// Carry generation is left to the surrounding controller.
module add1b (
   input  logic a_i,
   input  logic b_i,
   input  logic inv_i,
   input  logic c_i,
   output logic s_o,
   output logic x_o
);

   assign x_o = b_i ^ inv_i;
   assign s_o = a_i ^ x_o ^ c_i;

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract built around one add1b slice.
// Operands go LSB-first through the slice, one bit per clock; results land on the DONE cycle.
module serial_addsub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             sub_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] s_o,
   output logic             cout_o,
   output logic             ovf_o
);

   import serial_addsub_ctrl_pkg::*;

   localparam int               CNT_W    = clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e             state_q;
   logic [WIDTH-1:0]   opA_q;
   logic [WIDTH-1:0]   opB_q;
   logic [WIDTH-2:0]   shift_q;
   logic [WIDTH-1:0]   sum_q;
   logic [CNT_W-1:0]   bitCnt_q;
   logic               sub_q;
   logic               carry_q;
   logic               busy_q;
   logic               done_q;
   logic               cout_q;
   logic               ovf_q;

   logic               bitA;
   logic               bitB;
   logic               sliceS;
   logic               sliceX;
   logic               carry_d;

   assign bitA    = opA_q[bitCnt_q];
   assign bitB    = opB_q[bitCnt_q];
   assign carry_d = (bitA & sliceX) | (carry_q & (bitA ^ sliceX));

   add1b u_slice (
      .a_i   (bitA),
      .b_i   (bitB),
      .inv_i (sub_q),
      .c_i   (carry_q),
      .s_o   (sliceS),
      .x_o   (sliceX)
   );

   // Result bits enter at the top of shift_q and drift down, so after WIDTH-1
   // cycles the first bit sits at bit 0 and the last bit completes the word.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         opA_q    <= '0;
         opB_q    <= '0;
         shift_q  <= '0;
         sum_q    <= '0;
         bitCnt_q <= '0;
         sub_q    <= 1'b0;
         carry_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               carry_q <= carry_d;
               if (bitCnt_q == LAST_BIT) begin
                  sum_q   <= {sliceS, shift_q};
                  cout_q  <= carry_d;
                  ovf_q   <= carry_q ^ carry_d;
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  shift_q  <= (WIDTH-1)'({sliceS, shift_q} >> 1);
                  bitCnt_q <= bitCnt_q + 1'b1;
               end
            end
            default: begin
               done_q <= 1'b0;
               if (start_i) begin
                  opA_q    <= a_i;
                  opB_q    <= b_i;
                  sub_q    <= sub_i;
                  carry_q  <= sub_i;
                  bitCnt_q <= '0;
                  state_q  <= RUN;
                  busy_q   <= 1'b1;
               end else begin
                  state_q  <= IDLE;
                  busy_q   <= 1'b0;
               end
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign s_o    = sum_q;
   assign cout_o = cout_q;
   assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed and random operations against
// an arithmetic reference model, plus a WIDTH=2 instance.
module tb_serial_addsub_ctrl;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic       start;
   logic       subIn;
   logic [7:0] aIn;
   logic [7:0] bIn;
   logic       busy;
   logic       done;
   logic [7:0] sOut;
   logic       cout;
   logic       ovf;

   logic       start2;
   logic       sub2;
   logic [1:0] a2;
   logic [1:0] b2;
   logic       busy2;
   logic       done2;
   logic [1:0] s2;
   logic       cout2;
   logic       ovf2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_addsub_ctrl #(.WIDTH(8)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .start_i (start),
      .sub_i   (subIn),
      .a_i     (aIn),
      .b_i     (bIn),
      .busy_o  (busy),
      .done_o  (done),
      .s_o     (sOut),
      .cout_o  (cout),
      .ovf_o   (ovf)
   );

   serial_addsub_ctrl #(.WIDTH(2)) dut2 (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .start_i (start2),
      .sub_i   (sub2),
      .a_i     (a2),
      .b_i     (b2),
      .busy_o  (busy2),
      .done_o  (done2),
      .s_o     (s2),
      .cout_o  (cout2),
      .ovf_o   (ovf2)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Plain w-bit two's-complement arithmetic: a + b or a + ~b + 1.
   function automatic void refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input bit sub, output logic [31:0] s,
                                    output bit co, output bit ov);
      longint mask;
      longint bb;
      longint full;
      bit     sa;
      bit     sb;
      bit     ss;
      mask = (longint'(1) << w) - 1;
      bb   = sub ? (~longint'(b) & mask) : (longint'(b) & mask);
      full = (longint'(a) & mask) + bb + (sub ? 1 : 0);
      s    = 32'(full & mask);
      co   = ((full >> w) & 1) != 0;
      sa   = a[w-1];
      sb   = b[w-1];
      ss   = s[w-1];
      ov   = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
   endfunction

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input bit sub);
      @(negedge clk);
      start = 1'b1;
      aIn   = a;
      bIn   = b;
      subIn = sub;
      @(negedge clk);
      start = 1'b0;
      aIn   = 8'($urandom);
      bIn   = 8'($urandom);
      subIn = 1'($urandom);
   endtask

   // Called at the negedge of RUN cycle 1; returns at the done cycle (or timeout).
   task automatic waitDone(input int injectAt, output int lat, output int busyCnt);
      lat     = 1;
      busyCnt = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) busyCnt++;
         if (lat == injectAt) begin
            start = 1'b1;
            aIn   = 8'hFF;
            bIn   = 8'hFF;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
   endtask

   task automatic checkResult(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input bit sub);
      logic [31:0] es;
      bit          ec;
      bit          eo;
      refModel(8, 32'(a), 32'(b), sub, es, ec, eo);
      checkOutput({tag, ".s"}, 32'(sOut), es);
      checkOutput({tag, ".cout"}, 32'(cout), 32'(ec));
      checkOutput({tag, ".ovf"}, 32'(ovf), 32'(eo));
      checkOutput({tag, ".busyAtDone"}, 32'(busy), 32'd0);
   endtask

   task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input bit sub, input int injectAt);
      int lat;
      int busyCnt;
      applyStimulus(a, b, sub);
      waitDone(injectAt, lat, busyCnt);
      checkOutput({tag, ".lat"}, 32'(lat), 32'd9);
      checkOutput({tag, ".busyCycles"}, 32'(busyCnt), 32'd8);
      checkResult(tag, a, b, sub);
   endtask

   initial begin
      int lat;
      int busyCnt;
      int doneSeen;
      logic [7:0] ra;
      logic [7:0] rb;
      bit         rs;

      rst_ni = 1'b0;
      start  = 1'b0;
      subIn  = 1'b0;
      aIn    = '0;
      bIn    = '0;
      start2 = 1'b0;
      sub2   = 1'b0;
      a2     = '0;
      b2     = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset.busy", 32'(busy), 32'd0);
      checkOutput("reset.done", 32'(done), 32'd0);
      checkOutput("reset.s", 32'(sOut), 32'd0);
      checkOutput("reset.flags", 32'({cout, ovf}), 32'd0);
      rst_ni = 1'b1;

      runOp("add5p3", 8'h05, 8'h03, 1'b0, -1);
      runOp("sub5m7", 8'h05, 8'h07, 1'b1, -1);
      runOp("sub7m5", 8'h07, 8'h05, 1'b1, -1);
      runOp("add7Fp1", 8'h7F, 8'h01, 1'b0, -1);
      runOp("sub80m1", 8'h80, 8'h01, 1'b1, -1);

      // A second start during RUN must be dropped entirely.
      runOp("ignoreStart", 8'h10, 8'h01, 1'b0, 3);
      @(negedge clk);
      checkOutput("ignoreStart.noSecondBusy", 32'(busy), 32'd0);
      checkOutput("ignoreStart.noSecondDone", 32'(done), 32'd0);

      // Reset in RUN cycle 4 clears everything at once and produces no done.
      applyStimulus(8'h33, 8'h44, 1'b0);
      repeat (3) @(negedge clk);
      rst_ni = 1'b0;
      #1;
      checkOutput("midReset.busy", 32'(busy), 32'd0);
      checkOutput("midReset.s", 32'(sOut), 32'd0);
      checkOutput("midReset.flags", 32'({cout, ovf, done}), 32'd0);
      doneSeen = 0;
      repeat (2) begin
         @(negedge clk);
         if (done === 1'b1) doneSeen++;
      end
      rst_ni = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (done === 1'b1) doneSeen++;
      end
      checkOutput("midReset.noDone", 32'(doneSeen), 32'd0);
      runOp("afterReset", 8'h0F, 8'h01, 1'b0, -1);

      // Back-to-back: start high in the DONE cycle begins the next op immediately.
      runOp("b2bFirst", 8'hC8, 8'h64, 1'b1, -1);
      start = 1'b1;
      aIn   = 8'h9A;
      bIn   = 8'hB7;
      subIn = 1'b0;
      @(negedge clk);
      checkOutput("b2b.busyAfterDone", 32'(busy), 32'd1);
      checkOutput("b2b.doneCleared", 32'(done), 32'd0);
      waitDone(-1, lat, busyCnt);
      checkOutput("b2bSecond.lat", 32'(lat), 32'd9);
      checkResult("b2bSecond", 8'h9A, 8'hB7, 1'b0);

      for (int i = 0; i < 16; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom);
         runOp($sformatf("rand%0d", i), ra, rb, rs, -1);
      end

      // WIDTH=2 instance: 0b11 + 0b01.
      @(negedge clk);
      start2 = 1'b1;
      a2     = 2'b11;
      b2     = 2'b01;
      sub2   = 1'b0;
      @(negedge clk);
      start2 = 1'b0;
      lat    = 1;
      while (done2 !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("w2.lat", 32'(lat), 32'd3);
      checkOutput("w2.s", 32'(s2), 32'd0);
      checkOutput("w2.cout", 32'(cout2), 32'd1);
      checkOutput("w2.ovf", 32'(ovf2), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
